// File: rtl/pc_sequencer.sv
// Next-PC controller for the MIPS fetch stage: picks the next fetch address from
// sequential/branch/jump/JR sources, handles stalls and halt, and counts issued fetches.
module pc_sequencer #(
  parameter logic [31:0] FIRST_ADDRESS = 32'h0000_0000,
  parameter logic [31:0] PC_INC        = 32'd4,
  parameter logic [31:0] HALT_ADDRESS  = 32'h0000_007C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        branch_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump_req,
  input  logic [25:0] jump_index,
  input  logic        jr_req,
  input  logic [31:0] jr_addr,
  output logic [31:0] target,
  output logic        pc_load,
  output logic        flush,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] seq_addr;
  logic [31:0] branch_addr;

  assign seq_addr    = pc_in + PC_INC;
  assign branch_addr = seq_addr + {branch_offset[29:0], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_START;
      fetch_count_q <= 32'd0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // The halting load itself is counted; pc_load is only ever high in RUN.
  always_comb begin
    state_d       = state_q;
    fetch_count_d = fetch_count_q;
    misaligned_d  = misaligned_q;
    case (state_q)
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (pc_load) begin
          fetch_count_d = fetch_count_q + 32'd1;
          if (jr_req && (jr_addr[1:0] != 2'b00)) begin
            misaligned_d = 1'b1;
          end else begin
            misaligned_d = misaligned_q;
          end
          if (target == HALT_ADDRESS) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_START;
    endcase
  end

  always_comb begin
    target  = FIRST_ADDRESS;
    pc_load = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_START: begin
        target  = FIRST_ADDRESS;
        pc_load = 1'b0;
        flush   = 1'b0;
      end
      ST_RUN: begin
        pc_load = ~stall;
        if (jr_req) begin
          target = {jr_addr[31:2], 2'b00};
          flush  = ~stall;
        end else if (jump_req) begin
          target = {seq_addr[31:28], jump_index, 2'b00};
          flush  = ~stall;
        end else if (branch_req && branch_taken) begin
          target = branch_addr;
          flush  = ~stall;
        end else begin
          target = seq_addr;
          flush  = 1'b0;
        end
      end
      ST_HALT: begin
        target  = HALT_ADDRESS;
        pc_load = 1'b0;
        flush   = 1'b0;
      end
      default: begin
        target  = FIRST_ADDRESS;
        pc_load = 1'b0;
        flush   = 1'b0;
      end
    endcase
  end

  assign halted      = (state_q == ST_HALT);
  assign misaligned  = misaligned_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with hand-computed expected values
// plus hand-written sequences for reset, stall, halt and counter wrap.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        stall;
  logic        branch_req;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump_req;
  logic [25:0] jump_index;
  logic        jr_req;
  logic [31:0] jr_addr;
  logic [31:0] target;
  logic        pc_load;
  logic        flush;
  logic        halted;
  logic        misaligned;
  logic [31:0] fetch_count;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_count;
  logic        exp_mis;

  typedef struct {
    logic [31:0] pc;
    logic        stl;
    logic        br_req;
    logic        br_tkn;
    logic [31:0] br_off;
    logic        j_req;
    logic [25:0] j_idx;
    logic        jr;
    logic [31:0] jr_a;
    logic [31:0] exp_target;
    logic        exp_load;
    logic        exp_flush;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .stall(stall),
    .branch_req(branch_req), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_req(jump_req), .jump_index(jump_index), .jr_req(jr_req), .jr_addr(jr_addr),
    .target(target), .pc_load(pc_load), .flush(flush), .halted(halted),
    .misaligned(misaligned), .fetch_count(fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input logic [31:0] pc);
    pc_in = pc; stall = 1'b0; branch_req = 1'b0; branch_taken = 1'b0;
    branch_offset = 32'd0; jump_req = 1'b0; jump_index = 26'd0; jr_req = 1'b0; jr_addr = 32'd0;
  endtask

  task automatic drive(input vec_t v);
    pc_in = v.pc; stall = v.stl; branch_req = v.br_req; branch_taken = v.br_tkn;
    branch_offset = v.br_off; jump_req = v.j_req; jump_index = v.j_idx;
    jr_req = v.jr; jr_addr = v.jr_a;
  endtask

  // Advance one edge and land away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_outs(input string name, input logic [31:0] t, input logic l, input logic f);
    check({name, ".target"}, target, t);
    check({name, ".pc_load"}, {31'd0, pc_load}, {31'd0, l});
    check({name, ".flush"}, {31'd0, flush}, {31'd0, f});
  endtask

  task automatic check_regs(input string name, input logic h);
    check({name, ".fetch_count"}, fetch_count, exp_count);
    check({name, ".misaligned"}, {31'd0, misaligned}, {31'd0, exp_mis});
    check({name, ".halted"}, {31'd0, halted}, {31'd0, h});
  endtask

  initial begin
    //          pc            stl   brq   brt   off            jq    idx            jr    jr_addr        target         ld    fl
    vecs[0]  = '{32'h0000_0010, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0,       1'b0, 32'h0,        32'h0000_000C, 1'b1, 1'b1};
    vecs[1]  = '{32'h0000_0010, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 26'h0,       1'b0, 32'h0,        32'h0000_0014, 1'b1, 1'b0};
    vecs[2]  = '{32'h0000_0020, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 26'h0,       1'b0, 32'h0,        32'h0000_0024, 1'b1, 1'b0};
    vecs[3]  = '{32'h2000_0040, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 26'h10,      1'b1, 32'h0000_0101, 32'h0000_0100, 1'b0, 1'b0};
    vecs[4]  = '{32'h2000_0040, 1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 26'h10,      1'b1, 32'h0000_0103, 32'h0000_0100, 1'b1, 1'b1};
    vecs[5]  = '{32'h2000_0040, 1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 26'h10,      1'b0, 32'h0000_0103, 32'h2000_0040, 1'b1, 1'b1};
    vecs[6]  = '{32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,        32'h0000_0104, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0010, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0,       1'b0, 32'h0,        32'h0000_000C, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,        32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 32'h0000_0200, 32'h0000_0200, 1'b1, 1'b1};
    vecs[10] = '{32'h0000_1000, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 26'h0,       1'b0, 32'h0,        32'h0000_1044, 1'b1, 1'b1};
    vecs[11] = '{32'hF000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,       32'hFFFF_FFFC, 1'b1, 1'b1};

    exp_count = 32'd0;
    exp_mis   = 1'b0;
    idle(32'd0);
    reset = 1'b1;
    #3;
    check_outs("reset", 32'h0, 1'b0, 1'b0);
    check_regs("reset", 1'b0);
    #9;
    reset = 1'b0;
    #1;
    check_outs("start", 32'h0, 1'b0, 1'b0);
    tick();
    check_outs("first_run", 32'h4, 1'b1, 1'b0);
    tick();
    exp_count = 32'd1;
    check_regs("first_load", 1'b0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_target, vecs[i].exp_load, vecs[i].exp_flush);
      tick();
      if (vecs[i].exp_load) exp_count = exp_count + 32'd1;
      if (vecs[i].exp_load && vecs[i].jr && (vecs[i].jr_a[1:0] != 2'b00)) exp_mis = 1'b1;
      check_regs($sformatf("vec%0d", i), 1'b0);
    end

    // Taken branch held under stall for three cycles, then released.
    drive(vecs[7]);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_outs($sformatf("stall%0d", c), 32'h0000_000C, 1'b0, 1'b0);
      tick();
      check_regs($sformatf("stall%0d", c), 1'b0);
    end
    stall = 1'b0;
    #1;
    check_outs("stall_release", 32'h0000_000C, 1'b1, 1'b1);
    tick();
    exp_count = exp_count + 32'd1;
    check_regs("stall_release", 1'b0);

    // Halt address under stall must not halt.
    idle(32'h78);
    stall = 1'b1;
    #1;
    check_outs("halt_stalled", 32'h7C, 1'b0, 1'b0);
    tick();
    check_regs("halt_stalled", 1'b0);
    stall = 1'b0;
    #1;
    check_outs("halt_load", 32'h7C, 1'b1, 1'b0);
    tick();
    exp_count = exp_count + 32'd1;
    check_regs("halt_entered", 1'b1);
    check_outs("halted", 32'h7C, 1'b0, 1'b0);
    jump_req = 1'b1;
    jump_index = 26'h40;
    #1;
    check_outs("halt_jump", 32'h7C, 1'b0, 1'b0);
    tick();
    check_regs("halt_jump", 1'b1);

    // Reset in the middle of a cycle clears everything immediately.
    #1;
    reset = 1'b1;
    #1;
    exp_count = 32'd0;
    exp_mis = 1'b0;
    check_outs("reset2", 32'h0, 1'b0, 1'b0);
    check_regs("reset2", 1'b0);
    idle(32'hFFFF_FFFC);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outs("start2", 32'h0, 1'b0, 1'b0);
    tick();
    check_outs("wrap_target", 32'h0, 1'b1, 1'b0);

    // Counter wrap from all-ones.
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    #1;
    exp_count = 32'hFFFF_FFFF;
    check("wrap_preload", fetch_count, exp_count);
    tick();
    exp_count = 32'd0;
    check_regs("wrap_count", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
